// File: rtl/rt_store_commit_ctrl_pkg.sv
// Shared types for the retire-stage store commit path.
package rt_store_commit_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int RT_LANES = 3;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } mem_size_e;

  // One retired store as presented by stage_rt on each lane.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_e       mem_size;
  } rt_st_packet_t;

  // What the commit FIFO actually stores (valid is implied by occupancy).
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_e       mem_size;
  } cmt_entry_t;

  typedef enum logic {
    CMT_IDLE = 1'b0,
    CMT_BUSY = 1'b1
  } cmt_state_e;

  // Number of set bits in a 3-lane vector.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/rt_store_commit_ctrl_fifo.sv
// In-order commit FIFO: 3 lanes in (compacted at tail), 1 entry out at head.
module rt_store_commit_ctrl_fifo
  import rt_store_commit_ctrl_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  rt_st_packet_t enq_pkt_i [RT_LANES],
  input  logic          deq_i,
  output cmt_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic [CW-1:0] free_o,
  output logic          overflow_o
);

  cmt_entry_t          mem_q [DEPTH];
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       free_w, cap_w;
  logic                deq_eff;
  logic [RT_LANES-1:0] valid_vec, keep;
  logic [1:0]          rank [RT_LANES];
  logic [1:0]          n_enq;

  // A pop only ever happens with something to pop; guards against stray acks.
  assign deq_eff = deq_i && (count_q != '0);
  assign free_w  = CW'(DEPTH) - count_q;
  // Actual room this edge: the slot freed by a same-edge pop is reusable,
  // even though free_o (what the ROB sees) does not advertise it.
  assign cap_w   = free_w + CW'(deq_eff);

  // Each lane's slot offset is the number of valid lanes below it; a lane is
  // kept only if that offset still fits, so the lowest lanes win on overflow.
  for (genvar gi = 0; gi < RT_LANES; gi++) begin : g_lane
    localparam logic [RT_LANES-1:0] BELOW = RT_LANES'((1 << gi) - 1);
    assign valid_vec[gi] = enq_pkt_i[gi].valid;
    assign rank[gi]      = popcount3(valid_vec & BELOW);
    assign keep[gi]      = valid_vec[gi] && (CW'(rank[gi]) < cap_w);
  end

  assign n_enq        = popcount3(keep);
  assign count_d      = count_q + CW'(n_enq) - CW'(deq_eff);
  assign overflow_o   = |(valid_vec & ~keep);
  assign head_o       = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign free_o       = free_w;

  // Storage write: kept lanes land at consecutive slots from the tail.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int li = 0; li < RT_LANES; li++) begin
        if (keep[li]) begin
          mem_q[tail_q + PW'(rank[li])] <= {enq_pkt_i[li].addr,
                                            enq_pkt_i[li].data,
                                            enq_pkt_i[li].mem_size};
        end
      end
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PW'(n_enq);
      if (deq_eff) head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rt_store_commit_ctrl.sv
// Commits retired stores to the data-memory port in order, sharing the port
// with LSQ loads, and tells stage_rt when stores are still outstanding.
module rt_store_commit_ctrl
  import rt_store_commit_ctrl_pkg::*;
#(
  parameter int CQ_DEPTH  = 8,
  parameter int URGENT_TH = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  rt_st_packet_t              rt_st_packet [RT_LANES],
  input  logic                       halt_pending,
  input  logic                       ld_req,
  input  logic                       mem_ack,
  output logic                       ld_grant,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_data,
  output mem_size_e                  mem_size,
  output logic [$clog2(CQ_DEPTH):0]  free_slots,
  output logic                       rt_busy,
  output logic                       overflow_err
);

  localparam int CW = $clog2(CQ_DEPTH) + 1;

  cmt_state_e    state_q, state_d;
  logic          overflow_q;
  logic          deq;
  logic          store_wins;
  logic          fifo_ovf;
  logic [CW-1:0] count, count_next;
  cmt_entry_t    head;

  rt_store_commit_ctrl_fifo #(.DEPTH(CQ_DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .enq_pkt_i    (rt_st_packet),
    .deq_i        (deq),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .free_o       (free_slots),
    .overflow_o   (fifo_ovf)
  );

  // Stores take the port when no load wants it, when the queue is getting
  // full, or when stage_rt is waiting to halt.
  assign store_wins = !ld_req || (count >= CW'(URGENT_TH)) || halt_pending;

  // Next state and port outputs. The issue decision uses post-enqueue
  // occupancy so a store written this edge can request in the next cycle.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    ld_grant = 1'b0;
    deq      = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_size = MEM_BYTE;
    case (state_q)
      CMT_IDLE: begin
        ld_grant = ld_req && !((count != '0) && store_wins);
        if ((count_next != '0) && store_wins) state_d = CMT_BUSY;
      end
      CMT_BUSY: begin
        mem_req  = 1'b1;
        mem_addr = head.addr;
        mem_data = head.data;
        mem_size = head.mem_size;
        deq      = mem_ack;
        if (mem_ack) state_d = CMT_IDLE;
      end
      default: state_d = CMT_IDLE;
    endcase
  end

  assign rt_busy      = (count != '0) || (state_q == CMT_BUSY);
  assign overflow_err = overflow_q;

  // State register; reset abandons any request in flight.
  always_ff @(posedge clock) begin
    if (reset) state_q <= CMT_IDLE;
    else       state_q <= state_d;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_q | fifo_ovf;
  end

endmodule
